// File: rtl/ram_param_clr.sv
// Parametrised Hack-style RAM: combinational read, clocked write, post-reset clear sweep.
// Optional even-parity protection per word is enabled by defining RAM_PARITY_EN.
module ram_param_clr #(
  parameter int WIDTH        = 16,
  parameter int ADDR_W       = 6,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  in_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              inject_i,
  output logic [WIDTH-1:0]  out_o,
  output logic              ready_o,
  output logic              err_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_next;
  logic              r_ready;
  logic              w_clr_we;
  logic              w_usr_we;
  logic [WIDTH-1:0]  w_rd_word;

  logic [WIDTH-1:0]  r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_READY;
      r_clr_addr <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
      r_ready    <= (w_state_next == S_READY);
    end
  end

  // The sweep leaves CLEAR on the same edge that zeroes the last word.
  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    case (r_state)
      S_CLEAR: begin
        w_clr_addr_next = r_clr_addr + 1'b1;
        if (&r_clr_addr) begin
          w_state_next = S_READY;
        end
      end
      default: begin
        w_state_next = S_READY;
      end
    endcase
  end

  always_comb begin
    w_clr_we = (r_state == S_CLEAR);
    w_usr_we = r_ready & load_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_clr_we) begin
        r_mem[r_clr_addr] <= '0;
      end else if (w_usr_we) begin
        r_mem[address_i] <= in_i;
      end
    end
  end

  assign w_rd_word = r_mem[address_i];
  assign out_o     = r_ready ? w_rd_word : '0;
  assign ready_o   = r_ready;

`ifdef RAM_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_clr_we) begin
        r_par[r_clr_addr] <= 1'b0;
      end else if (w_usr_we) begin
        r_par[address_i] <= (^in_i) ^ inject_i;
      end
    end
  end

  assign err_o = r_ready & ((^w_rd_word) != r_par[address_i]);
`else
  logic w_unused_inject;
  assign w_unused_inject = inject_i;
  assign err_o           = 1'b0;
`endif

endmodule

// File: tb/tb_ram_param_clr.sv
// Directed bench for ram_param_clr at default parameters (16 x 64).
module tb_ram_param_clr;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] in_i;
  logic        load_i;
  logic [5:0]  address_i;
  logic        inject_i;
  logic [15:0] out_o;
  logic        ready_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  ram_param_clr #(.WIDTH(16), .ADDR_W(6), .CLEAR_ON_RST(1)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_i     (in_i),
    .load_i   (load_i),
    .address_i(address_i),
    .inject_i (inject_i),
    .out_o    (out_o),
    .ready_o  (ready_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [5:0] a, input string tag, input logic [15:0] exp);
    load_i    = 1'b0;
    address_i = a;
    #1;
    check(tag, out_o, exp);
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic inj);
    load_i    = 1'b1;
    address_i = a;
    in_i      = d;
    inject_i  = inj;
    step();
    load_i    = 1'b0;
    inject_i  = 1'b0;
  endtask

  // Counts edges until ready_o rises, scanning addresses to confirm out_o stays gated.
  task automatic wait_ready(output int n, output int nonzero);
    n       = 0;
    nonzero = 0;
    while (!ready_o && n < 200) begin
      address_i = n[5:0];
      #1;
      if (out_o != 16'h0 || err_o) nonzero++;
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int nz;
    int bad;
    rst_i     = 1'b1;
    in_i      = '0;
    load_i    = 1'b0;
    address_i = '0;
    inject_i  = 1'b0;

    repeat (5) step();
    check("rst_ready", {31'b0, ready_o}, 32'd0);
    check("rst_out", {16'b0, out_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);

    rst_i = 1'b0;
    wait_ready(n, nz);
    check("clear_edges", n, 32'd64);
    check("clear_out_gated", nz, 32'd0);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      address_i = i[5:0];
      #1;
      if (out_o != 16'h0) bad++;
    end
    check("sweep_all_zero", bad, 32'd0);

    // Read-during-write on addr 3: old word before the edge, new word after.
    load_i = 1'b1; address_i = 6'd3; in_i = 16'hEFFF;
    #1;
    check("rdw_old", {16'b0, out_o}, 32'h0000);
    step();
    check("rdw_new", {16'b0, out_o}, 32'hEFFF);
    step();
    rd(6'd3, "rd_a3", 16'hEFFF);
    rd(6'd2, "rd_a2_zero", 16'h0000);

    wr(6'd2, 16'h1234, 1'b0);
    rd(6'd3, "rd_a3_keep", 16'hEFFF);
    rd(6'd2, "rd_a2", 16'h1234);
    wr(6'd63, 16'hA5A5, 1'b0);
    rd(6'd63, "rd_a63", 16'hA5A5);
    rd(6'd0, "rd_a0_keep", 16'h0000);

`ifdef RAM_PARITY_EN
    wr(6'd7, 16'h0001, 1'b1);
    address_i = 6'd7; #1;
    check("par_inject_err", {31'b0, err_o}, 32'd1);
    wr(6'd7, 16'h0001, 1'b0);
    address_i = 6'd7; #1;
    check("par_clean_err", {31'b0, err_o}, 32'd0);
`else
    wr(6'd7, 16'h0001, 1'b1);
    address_i = 6'd7; #1;
    check("noparity_err", {31'b0, err_o}, 32'd0);
`endif
    rd(6'd7, "rd_a7", 16'h0001);

    // Reset while READY drops ready_o on that edge.
    rst_i = 1'b1;
    step();
    check("rst_drop_ready", {31'b0, ready_o}, 32'd0);
    rst_i = 1'b0;

    // Interrupt the sweep after 20 edges with writes attempted throughout.
    load_i = 1'b1; address_i = 6'd5; in_i = 16'hFFFF;
    repeat (20) step();
    check("midclear_ready", {31'b0, ready_o}, 32'd0);
    rst_i = 1'b1;
    step();
    check("midclear_rst_ready", {31'b0, ready_o}, 32'd0);
    rst_i = 1'b0;
    n = 0;
    while (!ready_o && n < 200) begin
      step();
      n++;
    end
    load_i = 1'b0;
    check("reclear_edges", n, 32'd64);
    rd(6'd5, "ignored_wr_a5", 16'h0000);
    rd(6'd3, "recleared_a3", 16'h0000);
    rd(6'd63, "recleared_a63", 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_param_clr.md
Name: ram_param_clr

Overview:
- Parametrised successor to the fixed 16-bit × 64-word Hack RAM.
- Generalises word width and depth, and keeps Hack semantics: combinational read, write on the clock edge when load is high.
- Adds a hardware clear sequencer that zeroes every word after reset, with a ready flag.
- Sits in the memory hierarchy as the building block for larger banked RAMs (RAM512/4K/16K-style composition).

Parameters:
- WIDTH, 16, data word width in bits (≥1)
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words
- CLEAR_ON_RST, 1, 1 = run the clear sweep after reset; 0 = skip the sweep and preserve contents

Ports:
- clk_i  input  1  single clock, rising edge
- rst_i  input  1  synchronous, active-high reset
- in_i  input  WIDTH  write data
- load_i  input  1  write enable (1 = write, 0 = read)
- address_i  input  ADDR_W  word address
- inject_i  input  1  parity error injection on write (used only with RAM_PARITY_EN)
- out_o  output  WIDTH  read data = mem[address_i]
- ready_o  output  1  1 when the RAM accepts accesses
- err_o  output  1  parity mismatch on the current read word

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- State machine, two states: CLEAR and READY.
- rst_i sampled high at an edge:
  - state <= CLEAR (or READY if CLEAR_ON_RST=0), clr_addr <= 0, ready_o <= 0.
  - No memory writes while rst_i is held high.
  - Reset values: ready_o = 0, err_o = 0, out_o = 0.
- CLEAR, rst_i low, each edge:
  - mem[clr_addr] <= 0, clr_addr <= clr_addr + 1.
  - The edge that writes word DEPTH-1 moves to READY and sets ready_o = 1.
  - ready_o therefore rises exactly DEPTH edges after the first edge with rst_i low.
- CLEAR_ON_RST=0: the first edge with rst_i low sets ready_o = 1; memory contents are untouched.
- In CLEAR, load_i, in_i and address_i are ignored.
- Output gating:
  - out_o = 0 whenever ready_o = 0.
  - out_o = mem[address_i] combinationally whenever ready_o = 1.
- Writes (READY only): load_i = 1 at an edge writes mem[address_i] <= in_i.
- Read-during-write: out_o shows the old word before the edge and the new word after it (combinational read-after-write, Hack semantics).
- Address range: address_i spans exactly DEPTH words, so no out-of-range case exists; clr_addr wraps naturally after DEPTH-1.
- Reset mid-clear or mid-operation: the sweep restarts from 0 and ready_o drops on that edge. Words already written keep their values until the sweep reaches them.
- Width rule: in_i is stored unmodified at WIDTH bits; there is no sign handling or truncation.

Optional Feature:
- Macro: RAM_PARITY_EN.
- With the macro:
  - Each word gets one extra even-parity bit.
  - On a write, par[address_i] <= ^in_i ^ inject_i.
  - The clear sweep writes parity 0.
  - err_o = ready_o & ((^mem[address_i]) != par[address_i]), combinational.
- Without the macro:
  - No parity storage.
  - inject_i is ignored.
  - err_o is tied to 0.

Test Plan:
1. Clear timing (defaults WIDTH=16, ADDR_W=6): hold rst_i high for 5 cycles, then release -> ready_o = 0 for exactly 64 edges, then 1. out_o = 0 throughout. Afterwards, a read of every address returns 0x0000.
2. Basic write/read: load=1, addr=3, in=0xEFFF for 2 cycles; then load=0, read addr 3 -> 0xEFFF; read addr 2 -> 0x0000.
3. Write then readback at other addresses:
   - Write 0x1234 to addr 2; read addr 3 -> still 0xEFFF; read addr 2 -> 0x1234.
   - Write 0xA5A5 to addr 63 (wrap boundary); read addr 63 -> 0xA5A5; addr 0 unchanged.
4. Reset mid-clear: assert rst_i for 1 cycle after 20 clear edges -> ready_o stays 0, and ready_o rises 64 edges after the new release.
5. Ignored writes during clear: load=1, addr=5, in=0xFFFF during CLEAR -> after ready_o = 1, addr 5 reads 0x0000.
6. Parity (RAM_PARITY_EN defined):
   - Write 0x0001 to addr 7 with inject_i=1 -> reading addr 7 gives err_o = 1.
   - Rewrite addr 7 with inject_i=0 -> err_o = 0.
   - Without the macro, err_o = 0 in all cases.
